mul_scheduler: RTL and testbench
================================

// Module: mul_scheduler
// PURPOSE
//  Front-end sequencer that sits directly upstream of the 64x64 signed Booth multiplier.
//  - Accepts operand pairs over a valid/ready stream and buffers them in a FIFO.
//  - Drives op_start/op_clear on the multiplier, then captures the 128-bit product into a
//    single-entry result slot with a valid/ready handshake, carrying a tag end to end.
//  - Includes a done-timeout watchdog.
// PARAMETERS
//  FIFO_DEPTH  4    operand FIFO entries; power of two, >=2
//  TAG_W       4    width of the user tag carried with each operation
//  TIMEOUT     255  max cycles in WAIT without mul_op_done before abort (multiplier worst case ~200)
// PORTS
//  clk               in   1        clock, rising edge
//  reset_n           in   1        asynchronous active-low reset
//  in_valid          in   1        operand pair valid
//  in_ready          out  1        FIFO can accept (registered; = !full)
//  in_multiplier     in   64       signed multiplier operand
//  in_multiplicand   in   64       signed multiplicand operand
//  in_tag            in   TAG_W    user tag
//  out_valid         out  1        result slot holds a product
//  out_ready         in   1        consumer takes result
//  out_result        out  128      signed product
//  out_tag           out  TAG_W    tag of out_result
//  mul_multiplier    out  64       to multiplier.multiplier (registered, held)
//  mul_multiplicand  out  64       to multiplier.multiplicand (registered, held)
//  mul_op_start      out  1        to multiplier.op_start (1-cycle pulse)
//  mul_op_clear      out  1        to multiplier.op_clear (1-cycle pulse)
//  mul_op_done       in   1        from multiplier.op_done
//  mul_result        in   128      from multiplier.result
//  busy              out  1        FSM not in IDLE, or FIFO non-empty
//  err_timeout       out  1        sticky: a watchdog abort occurred
//  err_clr           in   1        clears err_timeout (reset beats set; set beats clr)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - FSM to IDLE; FIFO empty; all outputs 0, except in_ready=1 after reset deasserts.
//  FIFO:
//  - Push on in_valid & in_ready. Pop only in ISSUE. No push-bypass when full.
//  - Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle keep the level.
//  Operand registers:
//  - Loaded from the FIFO head in ISSUE; held until the next ISSUE.
//  - The multiplier samples them one cycle after op_start.
//  FSM states:
//  - IDLE: FIFO non-empty -> ISSUE.
//  - ISSUE: mul_op_start=1 for one cycle; pop FIFO; load tag; clear watchdog -> WAIT.
//  - WAIT: watchdog counts up.
//    - mul_op_done & !out_valid: capture mul_result/tag into slot, set out_valid -> CLEAR.
//    - mul_op_done & out_valid: -> HOLD.
//    - watchdog == TIMEOUT: set err_timeout, no result produced -> CLEAR.
//  - HOLD: the multiplier keeps its result valid until op_clear.
//    - When the slot frees (!out_valid, or out_valid & out_ready this cycle): capture -> CLEAR.
//  - CLEAR: mul_op_clear=1 for one cycle (mandatory between ops; it rearms the multiplier's
//    iteration counter).
//    - FIFO non-empty -> ISSUE; else -> IDLE.
//  Protocol rules:
//  - mul_op_start and mul_op_clear are never asserted in the same cycle.
//  - mul_op_start is asserted only when the multiplier is known idle.
//  Result slot:
//  - out_valid clears on out_valid & out_ready unless recaptured that same cycle
//    (capture wins; new data replaces old).
//  - out_result/out_tag are stable while out_valid & !out_ready.
//  Ordering and throughput:
//  - Results emerge strictly in accept order.
//  - Scheduler overhead per op: 1 cycle ISSUE + 1 cycle CLEAR (+ HOLD stall).
//  - Latency: accept at edge N -> mul_op_start in cycle N+1 (IDLE at N+1 only if FIFO was empty,
//    else the same) -> out_valid the cycle after mul_op_done.
//  Reset mid-operation: everything aborts; no partial result, no pulse outputs afterwards.
//  Arithmetic: pass-through only; no sign or width manipulation of the product.
// TESTING
//  1. Push (3,5,tag=1), out_ready=1 -> one op_start pulse; out_result=15, out_tag=1; one op_clear after done.
//  2. Push (-7,6) -> out_result=128'hFFFF...FFD6 (-42). Push (0x8000..0, 0x8000..0) -> out_result=2^126.
//  3. out_ready=0; push 6 ops back-to-back -> in_ready drops after 4 queued + 1 issued; results 1..6
//     in order once out_ready=1; HOLD visible; op_clear never overlaps op_start.
//  4. Multiplier stub never asserts done -> after 255 WAIT cycles: err_timeout=1, op_clear pulse,
//     no out_valid. err_clr -> 0. The next op completes normally.
//  5. Assert reset_n=0 during WAIT -> all outputs 0 immediately. After release, a new op
//     gives a correct product.
//  6. out_ready toggling every cycle, 50 random signed pairs -> every product matches reference;
//     no drop or duplicate.

Source files
------------

// File: rtl/mul_scheduler_if.sv
// Operand/result stream bundle between mul_scheduler and its producer/consumer.
//   in_valid/in_ready        operand pair handshake (in_multiplier, in_multiplicand, in_tag)
//   out_valid/out_ready      result slot handshake (out_result, out_tag)
// slave  : the scheduler side (accepts operands, presents results)
// master : the producer/consumer side
`timescale 1ns/1ps
interface mul_scheduler_if #(
   parameter int unsigned TAG_W = 4
) ();
   localparam int unsigned OP_W  = 64;
   localparam int unsigned RES_W = 128;

   logic               in_valid;
   logic               in_ready;
   logic [OP_W-1:0]    in_multiplier;
   logic [OP_W-1:0]    in_multiplicand;
   logic [TAG_W-1:0]   in_tag;

   logic               out_valid;
   logic               out_ready;
   logic [RES_W-1:0]   out_result;
   logic [TAG_W-1:0]   out_tag;

   modport slave (
      input  in_valid, in_multiplier, in_multiplicand, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );

   modport master (
      output in_valid, in_multiplier, in_multiplicand, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/mul_scheduler.sv
// Sequencer in front of the 64x64 signed Booth multiplier: buffers operand pairs in a
// FIFO, issues them one at a time with op_start/op_clear pulses, parks each 128-bit
// product with its tag in a single-entry result slot, and aborts a stuck op by watchdog.
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   io (slave)              operand stream in, result slot out (see mul_scheduler_if)
//   mul_multiplier/_multiplicand  held operands to the multiplier
//   mul_op_start/_op_clear  one-cycle control pulses to the multiplier
//   mul_op_done, mul_result status/product from the multiplier
//   busy                    FSM active or operands queued
//   err_timeout, err_clr    sticky watchdog flag and its clear
`timescale 1ns/1ps
module mul_scheduler #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TAG_W      = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic          clk,
   input  logic          reset_n,
   mul_scheduler_if.slave io,
   output logic [63:0]   mul_multiplier,
   output logic [63:0]   mul_multiplicand,
   output logic          mul_op_start,
   output logic          mul_op_clear,
   input  logic          mul_op_done,
   input  logic [127:0]  mul_result,
   output logic          busy,
   output logic          err_timeout,
   input  logic          err_clr
);

   localparam int unsigned OP_W  = 64;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [OP_W-1:0]  multiplicand;
      logic [OP_W-1:0]  multiplier;
   } entry_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD,
      CLEAR
   } state_t;

   state_t            state;
   state_t            state_next;
   entry_t            mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [WD_W-1:0]   wdog;
   logic [TAG_W-1:0]  cur_tag;
   logic              push;
   logic              pop;
   logic              capture;
   logic              abort;
   logic              fifo_empty;

   assign push       = io.in_valid & io.in_ready;
   assign fifo_empty = (count == '0);

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Next-state and per-cycle strobes
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      capture    = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_next = ISSUE;
         end
         ISSUE: begin
            pop        = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (mul_op_done) begin
               if (!io.out_valid) begin
                  capture    = 1'b1;
                  state_next = CLEAR;
               end else begin
                  state_next = HOLD;
               end
            end else if (wdog == WD_W'(TIMEOUT)) begin
               abort      = 1'b1;
               state_next = CLEAR;
            end
         end
         HOLD: begin
            // slot frees either because it is empty or is being drained this cycle
            if (!io.out_valid || io.out_ready) begin
               capture    = 1'b1;
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            state_next = fifo_empty ? IDLE : ISSUE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // FIFO storage (no reset needed; guarded by count)
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{tag: io.in_tag, multiplicand: io.in_multiplicand,
                                 multiplier: io.in_multiplier};
   end

   // Pointers, operands, watchdog, result slot and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         io.in_ready      <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
         cur_tag          <= '0;
         wdog             <= '0;
         io.out_valid     <= 1'b0;
         io.out_result    <= '0;
         io.out_tag       <= '0;
         mul_op_start     <= 1'b0;
         mul_op_clear     <= 1'b0;
         busy             <= 1'b0;
         err_timeout      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr           <= rd_ptr + PTR_W'(1);
            mul_multiplier   <= mem[rd_ptr].multiplier;
            mul_multiplicand <= mem[rd_ptr].multiplicand;
            cur_tag          <= mem[rd_ptr].tag;
         end
         count       <= count_next;
         io.in_ready <= (count_next != CNT_W'(FIFO_DEPTH));

         if (state == ISSUE)     wdog <= '0;
         else if (state == WAIT) wdog <= wdog + WD_W'(1);

         // capture wins over a same-cycle drain
         if (capture) begin
            io.out_valid  <= 1'b1;
            io.out_result <= mul_result;
            io.out_tag    <= cur_tag;
         end else if (io.out_ready) begin
            io.out_valid  <= 1'b0;
         end

         mul_op_start <= (state_next == ISSUE);
         mul_op_clear <= (state_next == CLEAR);
         busy         <= (state_next != IDLE) || (count_next != '0);

         if (abort)        err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler: directed operand pairs with hand-computed
// products feed a scoreboard queue; a negedge monitor pops and compares every result
// handed over on the output slot. A behavioural multiplier stub answers op_start.
`timescale 1ns/1ps
module tb_mul_scheduler;

   localparam int unsigned TAG_W = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [63:0]   mul_multiplier;
   logic [63:0]   mul_multiplicand;
   logic          mul_op_start;
   logic          mul_op_clear;
   logic          mul_op_done;
   logic [127:0]  mul_result;
   logic          busy;
   logic          err_timeout;
   logic          err_clr;

   mul_scheduler_if #(.TAG_W(TAG_W)) dif ();

   mul_scheduler #(
      .FIFO_DEPTH (4),
      .TAG_W      (TAG_W),
      .TIMEOUT    (255)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .io               (dif),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_op_start     (mul_op_start),
      .mul_op_clear     (mul_op_clear),
      .mul_op_done      (mul_op_done),
      .mul_result       (mul_result),
      .busy             (busy),
      .err_timeout      (err_timeout),
      .err_clr          (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0]     res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    checks = 0;
   int    errors = 0;
   int    start_cnt = 0;
   int    clr_cnt = 0;
   int    rx_cnt = 0;

   function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] ae;
      logic signed [127:0] be;
      ae = {{64{a[63]}}, a};
      be = {{64{b[63]}}, b};
      return ae * be;
   endfunction

   // ---------------- multiplier stub ----------------
   localparam logic [1:0] S_IDLE = 2'd0, S_SAMPLE = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;
   logic [1:0]  sst;
   logic [63:0] op_a;
   logic [63:0] op_b;
   int          stub_cnt;
   int          stub_lat = 3;
   logic        stub_hang = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sst         <= S_IDLE;
         mul_op_done <= 1'b0;
         mul_result  <= '0;
         stub_cnt    <= 0;
      end else begin
         case (sst)
            S_IDLE:   if (mul_op_start) sst <= S_SAMPLE;
            S_SAMPLE: begin
               op_a     <= mul_multiplier;
               op_b     <= mul_multiplicand;
               stub_cnt <= stub_lat;
               sst      <= S_RUN;
            end
            S_RUN: begin
               if (mul_op_clear) sst <= S_IDLE;
               else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
               else if (!stub_hang) begin
                  mul_op_done <= 1'b1;
                  mul_result  <= ref_mul(op_a, op_b);
                  sst         <= S_DONE;
               end
            end
            default: if (mul_op_clear) begin
               mul_op_done <= 1'b0;
               sst         <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic         held = 1'b0;
   logic [127:0] held_res;
   logic [TAG_W-1:0] held_tag;

   always @(negedge clk) begin
      if (!reset_n) begin
         held = 1'b0;
      end else begin
         if (mul_op_start) start_cnt++;
         if (mul_op_clear) clr_cnt++;
         if (mul_op_start || mul_op_clear) begin
            checks++;
            if ((mul_op_start && mul_op_clear) || (mul_op_start && sst != S_IDLE)) begin
               errors++;
               $display("FAIL protocol: start=%0b clear=%0b stub_state=%0d, required exclusive pulses and start only when idle",
                        mul_op_start, mul_op_clear, sst);
            end
         end
         if (held && dif.out_valid) begin
            checks++;
            if (dif.out_result !== held_res || dif.out_tag !== held_tag) begin
               errors++;
               $display("FAIL slot_stable: got %h tag %0d, required %h tag %0d",
                        dif.out_result, dif.out_tag, held_res, held_tag);
            end
         end
         held     = dif.out_valid && !dif.out_ready;
         held_res = dif.out_result;
         held_tag = dif.out_tag;
         if (dif.out_valid && dif.out_ready) begin
            checks++;
            rx_cnt++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got %h tag %0d, required no result",
                        dif.out_result, dif.out_tag);
            end else begin
               mon_e = sb.pop_front();
               if (dif.out_result !== mon_e.res || dif.out_tag !== mon_e.tag) begin
                  errors++;
                  $display("FAIL result: got %h tag %0d, required %h tag %0d",
                           dif.out_result, dif.out_tag, mon_e.res, mon_e.tag);
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic chk_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag,
                       input bit has_exp, input logic [127:0] exp_res);
      int   n;
      exp_t x;
      n = 0;
      dif.in_valid        = 1'b1;
      dif.in_multiplier   = a;
      dif.in_multiplicand = b;
      dif.in_tag          = tag;
      @(negedge clk);
      while (!dif.in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!dif.in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
         dif.in_valid = 1'b0;
         return;
      end
      if (has_exp) begin
         x.res = exp_res;
         x.tag = tag;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || dif.out_valid) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 5000) begin
         errors++;
         $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
      end
   endtask

   // ---------------- stimulus ----------------
   int  s0;
   int  c0;
   int  r0;
   int  n;
   bit  tog_en = 1'b0;
   logic [63:0] ra;
   logic [63:0] rb;

   initial begin
      reset_n             = 1'b0;
      dif.in_valid        = 1'b0;
      dif.in_multiplier   = '0;
      dif.in_multiplicand = '0;
      dif.in_tag          = '0;
      dif.out_ready       = 1'b0;
      err_clr             = 1'b0;
      tick(3);
      chk_bit("rst_in_ready", dif.in_ready, 1'b0);
      chk_bit("rst_out_valid", dif.out_valid, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_op_start", mul_op_start, 1'b0);
      chk_bit("rst_err", err_timeout, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(2);
      chk_bit("post_rst_in_ready", dif.in_ready, 1'b1);
      chk_bit("post_rst_busy", busy, 1'b0);

      // 1: single op 3*5
      dif.out_ready = 1'b1;
      s0 = start_cnt;
      c0 = clr_cnt;
      push(64'd3, 64'd5, 4'd1, 1'b1, 128'd15);
      drain("t1");
      chk_int("t1_start_pulses", start_cnt - s0, 1);
      chk_int("t1_clear_pulses", clr_cnt - c0, 1);

      // 2: signed corner products
      push(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 4'd2, 1'b1,
           128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFD6);
      push(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd3, 1'b1,
           128'h40000000_00000000_00000000_00000000);
      drain("t2");

      // 3: back-pressure, FIFO fill and HOLD
      dif.out_ready = 1'b0;
      for (int i = 1; i <= 6; i++)
         push(64'(i), 64'd1, 4'(i), 1'b1, 128'(i));
      @(negedge clk);
      chk_bit("t3_in_ready_full", dif.in_ready, 1'b0);
      tick(15);
      chk_bit("t3_slot_full", dif.out_valid, 1'b1);
      chk_bit("t3_hold_done_high", mul_op_done, 1'b1);
      c0 = clr_cnt;
      tick(5);
      chk_int("t3_no_clear_in_hold", clr_cnt - c0, 0);
      dif.out_ready = 1'b1;
      drain("t3");

      // 4: watchdog abort
      stub_hang = 1'b1;
      c0 = clr_cnt;
      r0 = rx_cnt;
      push(64'd9, 64'd9, 4'd4, 1'b0, '0);
      n = 0;
      while (!err_timeout && n < 600) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk_bit("t4_err_timeout", err_timeout, 1'b1);
      chk_int("t4_abort_delay_in_range", int'(n >= 250 && n <= 265), 1);
      tick(3);
      chk_int("t4_clear_pulse", clr_cnt - c0, 1);
      chk_bit("t4_no_out_valid", dif.out_valid, 1'b0);
      chk_int("t4_no_result", rx_cnt - r0, 0);
      chk_bit("t4_err_sticky", err_timeout, 1'b1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk_bit("t4_err_cleared", err_timeout, 1'b0);
      stub_hang = 1'b0;
      push(64'd12, 64'd12, 4'd9, 1'b1, 128'd144);
      drain("t4");

      // 5: reset during WAIT
      stub_lat = 20;
      push(64'd100, 64'd200, 4'd5, 1'b0, '0);
      tick(5);
      reset_n = 1'b0;
      #1;
      chk_bit("t5_in_ready", dif.in_ready, 1'b0);
      chk_bit("t5_busy", busy, 1'b0);
      chk_bit("t5_op_start", mul_op_start, 1'b0);
      chk_bit("t5_op_clear", mul_op_clear, 1'b0);
      chk("t5_mul_multiplier", 128'(mul_multiplier), '0);
      chk("t5_out_result", dif.out_result, '0);
      chk_bit("t5_out_valid", dif.out_valid, 1'b0);
      sb.delete();
      tick(2);
      @(negedge clk);
      reset_n = 1'b1;
      s0 = start_cnt;
      c0 = clr_cnt;
      tick(5);
      chk_int("t5_no_start_after_reset", start_cnt - s0, 0);
      chk_int("t5_no_clear_after_reset", clr_cnt - c0, 0);
      chk_bit("t5_in_ready_back", dif.in_ready, 1'b1);
      stub_lat = 3;
      push(64'hFFFF_FFFF_FFFF_FFFF, 64'd123456789, 4'hA, 1'b1,
           128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_F8A432EB);
      drain("t5");

      // 6: random signed pairs with out_ready toggling
      r0 = rx_cnt;
      tog_en = 1'b1;
      fork
         begin
            while (tog_en) begin
               @(posedge clk);
               #1;
               dif.out_ready = ~dif.out_ready;
            end
         end
      join_none
      for (int i = 0; i < 50; i++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         stub_lat = int'($urandom_range(0, 6));
         push(ra, rb, 4'(i), 1'b1, ref_mul(ra, rb));
      end
      tog_en = 1'b0;
      tick(3);
      dif.out_ready = 1'b1;
      drain("t6");
      chk_int("t6_result_count", rx_cnt - r0, 50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
